// File: rtl/gcd_req_driver.sv
// gcd_req_driver: table-driven val/rdy initiator and result checker that sits opposite a GCD unit.
// Optional feature macro GCD_REQ_DRIVER_STALL_EN adds LFSR-driven stalls on req_val/resp_rdy.
//
// state | meaning
// IDLE  | after reset, waiting for start; table writable
// RUN   | issuing requests and accepting responses
// DRAIN | all requests issued, collecting remaining responses
// DONE  | run finished (complete or timed out); results held, table writable
module gcd_req_driver #(
  parameter int NUM_ENTRIES = 8,
  parameter int W = 16,
  parameter int TIMEOUT = 1024,
  localparam int AW = $clog2(NUM_ENTRIES),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cfg_we,
  input  logic [AW-1:0] cfg_addr,
  input  logic [W-1:0]  cfg_a,
  input  logic [W-1:0]  cfg_b,
  input  logic [W-1:0]  cfg_exp,
  input  logic [CW-1:0] cfg_count,
  input  logic          start,
  output logic [W-1:0]  req_a,
  output logic [W-1:0]  req_b,
  output logic          req_val,
  input  logic          req_rdy,
  input  logic [W-1:0]  resp,
  input  logic          resp_val,
  output logic          resp_rdy,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [CW-1:0] err_count,
  output logic [AW-1:0] first_err,
  output logic          timeout
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(NUM_ENTRIES);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  tab_a [NUM_ENTRIES];
  logic [W-1:0]  tab_b [NUM_ENTRIES];
  logic [W-1:0]  tab_e [NUM_ENTRIES];
  logic [CW-1:0] issue_ptr, check_ptr, count_q, err_q;
  logic [AW-1:0] first_q;
  logic [TW-1:0] tcnt;
  logic          tmo_q, pass_q;
  logic          idle_or_done, start_ok, cfg_ok;
  logic [CW-1:0] count_in;
  logic          tmo_hit, req_fire, resp_fire, mismatch;
  logic          req_gate, resp_gate;

  assign idle_or_done = (state_q == S_IDLE) || (state_q == S_DONE);
  assign start_ok     = start && idle_or_done;
  assign cfg_ok       = cfg_we && idle_or_done;
  assign count_in     = (cfg_count > MAX_CNT) ? MAX_CNT : cfg_count;
  assign tmo_hit      = (tcnt == TW'(TIMEOUT));
  assign req_fire     = req_val && req_rdy;
  assign resp_fire    = resp_val && resp_rdy;
  assign mismatch     = (resp != tab_e[check_ptr[AW-1:0]]);

`ifdef GCD_REQ_DRIVER_STALL_EN
  logic [15:0] lfsr;
  logic        req_hold;

  // req_hold keeps a presented request up until it fires, whatever the LFSR says.
  always_ff @(posedge clk) begin
    if (!reset) begin
      lfsr     <= 16'hACE1;
      req_hold <= 1'b0;
    end else begin
      lfsr     <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
      req_hold <= req_val && !req_rdy;
    end
  end

  assign req_gate  = req_hold || (lfsr[1:0] != 2'b00);
  assign resp_gate = (lfsr[3:2] != 2'b00);
`else
  assign req_gate  = 1'b1;
  assign resp_gate = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (cfg_ok) begin
      tab_a[cfg_addr] <= cfg_a;
      tab_b[cfg_addr] <= cfg_b;
      tab_e[cfg_addr] <= cfg_exp;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) state_d = (count_in == '0) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        if (tmo_hit)                   state_d = S_DONE;
        else if (issue_ptr == count_q) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (tmo_hit || (check_ptr == count_q)) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q == S_RUN) || (state_q == S_DRAIN);
    done      = (state_q == S_DONE);
    req_val   = (state_q == S_RUN) && (issue_ptr < count_q) && req_gate;
    // No response is taken in the abort cycle so a late result never mixes with a timeout.
    resp_rdy  = busy && (check_ptr < issue_ptr) && resp_gate && !tmo_hit;
    req_a     = tab_a[issue_ptr[AW-1:0]];
    req_b     = tab_b[issue_ptr[AW-1:0]];
    pass      = pass_q;
    err_count = err_q;
    first_err = first_q;
    timeout   = tmo_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      issue_ptr <= '0;
      check_ptr <= '0;
      count_q   <= '0;
      err_q     <= '0;
      first_q   <= '0;
      tcnt      <= '0;
      tmo_q     <= 1'b0;
      pass_q    <= 1'b0;
    end else if (start_ok) begin
      issue_ptr <= '0;
      check_ptr <= '0;
      count_q   <= count_in;
      err_q     <= '0;
      first_q   <= '0;
      tcnt      <= '0;
      tmo_q     <= 1'b0;
      pass_q    <= (count_in == '0);
    end else if (busy) begin
      if (req_fire) issue_ptr <= issue_ptr + CW'(1);
      if (resp_fire) begin
        check_ptr <= check_ptr + CW'(1);
        tcnt      <= '0;
        if (mismatch) begin
          err_q <= err_q + CW'(1);
          if (err_q == '0) first_q <= check_ptr[AW-1:0];
        end
      end else if (!tmo_hit) begin
        tcnt <= tcnt + TW'(1);
      end
      if (state_d == S_DONE) begin
        tmo_q  <= tmo_hit;
        pass_q <= !tmo_hit && (err_q == '0);
      end
    end
  end

endmodule
